rom_loader: RTL and testbench

- Upstream stage of the 9-bit CPU: fills program ROM (dual-port block RAM) from a byte stream (UART receiver or debug bridge) before the CPU runs.
- Holds the CPU in reset while loading, writes each 9-bit instruction through the ROM write port and checks a frame checksum.
- Releases the CPU only after a good frame. A new frame may be loaded at any time.

---
 rtl/rom_loader.sv | 210 +++++++++++++++++++++
 tb/tb_rom_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rom_loader: receives a framed byte stream and writes it into the CPU program ROM.
// The CPU is held in reset while a frame loads. It is released only after a frame
// arrives with a matching XOR checksum.
// Frame: SYNC, LEN_LO, LEN_HI, LEN x {W_LO, W_HI}, CHK.
// Each word is {W_HI[0], W_LO}. CHK is the XOR of every byte after SYNC.
module rom_loader #(
    parameter int unsigned g_ROM_WIDTH = 9,
    parameter int unsigned g_ROM_ADDR  = 11,
    parameter int unsigned g_TIMEOUT   = 100000,
    parameter logic [7:0]  g_SYNC      = 8'hA5
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [7:0]             i_byte,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic                   o_rom_we,
    output logic [g_ROM_ADDR-1:0]  o_rom_addr,
    output logic [g_ROM_WIDTH-1:0] o_rom_data,
    output logic                   o_cpu_rst,
    output logic                   o_done,
    output logic                   o_err
);

    // The word counter is one bit wider than the address so that it can hold a
    // full-ROM LEN of 2^g_ROM_ADDR.
    localparam int unsigned CNT_W   = g_ROM_ADDR + 1;
    localparam int unsigned TO_W    = $clog2(g_TIMEOUT + 1);
    localparam logic [16:0] LEN_MAX = 17'(1) << g_ROM_ADDR;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_INS_LO,
        S_INS_HI,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic            accept;
    logic            in_frame;
    logic            timeout;
    logic [16:0]     len_full;
    logic            sync_hit, wr_word, enter_done, enter_err;
    logic            ld_len_lo, ld_len_hi, ld_ins_lo, csum_upd;
    logic [7:0]      len_lo_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] word_cnt_q;
    logic [7:0]      lo_q;
    logic [7:0]      csum_q;
    logic [TO_W-1:0] idle_q;

    assign accept   = i_valid & o_ready;
    assign in_frame = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_INS_LO) || (state_q == S_INS_HI) ||
                      (state_q == S_CHK);
    // When the timeout fires, it wins over a byte arriving in the same cycle, and that byte is dropped.
    assign timeout  = in_frame && (idle_q == TO_W'(g_TIMEOUT));
    assign len_full = {1'b0, i_byte, len_lo_q};

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-byte action strobes
    always_comb begin
        state_d    = state_q;
        sync_hit   = 1'b0;
        wr_word    = 1'b0;
        enter_done = 1'b0;
        enter_err  = 1'b0;
        ld_len_lo  = 1'b0;
        ld_len_hi  = 1'b0;
        ld_ins_lo  = 1'b0;
        csum_upd   = 1'b0;
        if (timeout) begin
            state_d   = S_ERR;
            enter_err = 1'b1;
        end else if (accept) begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (i_byte == g_SYNC) begin
                        state_d  = S_LEN_LO;
                        sync_hit = 1'b1;
                    end
                end
                S_LEN_LO: begin
                    ld_len_lo = 1'b1;
                    csum_upd  = 1'b1;
                    state_d   = S_LEN_HI;
                end
                S_LEN_HI: begin
                    ld_len_hi = 1'b1;
                    csum_upd  = 1'b1;
                    if (len_full > LEN_MAX) begin
                        state_d   = S_ERR;
                        enter_err = 1'b1;
                    end else if (len_full == 17'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_INS_LO;
                    end
                end
                S_INS_LO: begin
                    ld_ins_lo = 1'b1;
                    csum_upd  = 1'b1;
                    state_d   = S_INS_HI;
                end
                S_INS_HI: begin
                    wr_word  = 1'b1;
                    csum_upd = 1'b1;
                    if ((word_cnt_q + CNT_W'(1)) == len_q) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_INS_LO;
                    end
                end
                S_CHK: begin
                    if (i_byte == csum_q) begin
                        state_d    = S_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d   = S_ERR;
                        enter_err = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ROM write port: registered single-cycle strobe, one per completed word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rom_we   <= 1'b0;
            o_rom_addr <= '0;
            o_rom_data <= '0;
        end else begin
            o_rom_we <= wr_word;
            if (wr_word) begin
                o_rom_addr <= word_cnt_q[g_ROM_ADDR-1:0];
                o_rom_data <= g_ROM_WIDTH'({i_byte[0], lo_q});
            end
        end
    end

    // Frame bookkeeping: length, low byte, word index, running checksum
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len_lo_q   <= '0;
            len_q      <= '0;
            lo_q       <= '0;
            word_cnt_q <= '0;
            csum_q     <= '0;
        end else begin
            if (ld_len_lo) len_lo_q <= i_byte;
            if (ld_len_hi) len_q <= CNT_W'({i_byte, len_lo_q});
            if (ld_ins_lo) lo_q <= i_byte;
            if (sync_hit) begin
                word_cnt_q <= '0;
                csum_q     <= '0;
            end else begin
                if (wr_word)  word_cnt_q <= word_cnt_q + CNT_W'(1);
                if (csum_upd) csum_q <= csum_q ^ i_byte;
            end
        end
    end

    // Status outputs: CPU reset, done and error flags, always-ready handshake
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ready   <= 1'b0;
            o_cpu_rst <= 1'b1;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_ready <= 1'b1;
            if (sync_hit) begin
                o_cpu_rst <= 1'b1;
                o_done    <= 1'b0;
                o_err     <= 1'b0;
            end else if (enter_done) begin
                o_cpu_rst <= 1'b0;
                o_done    <= 1'b1;
            end else if (enter_err) begin
                o_err <= 1'b1;
            end
        end
    end

    // Inter-byte idle counter: runs only inside a frame, cleared by every accepted byte
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_q <= '0;
        end else if (!in_frame || (accept && !timeout)) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + TO_W'(1);
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader. Expected ROM writes are queued as stimulus is driven.
// They are popped and compared whenever the loader strobes o_rom_we.
module tb_rom_loader;

    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        i_byte;
    logic              i_valid;
    logic              o_ready;
    logic              o_rom_we;
    logic [ADDR_W-1:0] o_rom_addr;
    logic [8:0]        o_rom_data;
    logic              o_cpu_rst;
    logic              o_done;
    logic              o_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [ADDR_W+8:0] exp_q[$];   // {addr, data}
    logic [15:0]       frame_w[$]; // {W_HI, W_LO}

    always #5 clk = ~clk;

    rom_loader #(
        .g_ROM_WIDTH(9),
        .g_ROM_ADDR (ADDR_W),
        .g_TIMEOUT  (16),
        .g_SYNC     (8'hA5)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_byte    (i_byte),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_rom_we  (o_rom_we),
        .o_rom_addr(o_rom_addr),
        .o_rom_data(o_rom_data),
        .o_cpu_rst (o_cpu_rst),
        .o_done    (o_done),
        .o_err     (o_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ROM write monitor: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (o_rom_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL spurious_write: observed addr 0x%0h data 0x%0h expected no write",
                       o_rom_addr, o_rom_data);
            end else begin
                check("rom_write", 32'({o_rom_addr, o_rom_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [7:0] b);
        i_byte  = b;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends SYNC + frame_w as a frame. It queues the expected writes and computes CHK.
    task automatic send_frame(input bit bad_chk);
        logic [15:0] len;
        logic [7:0]  chk;
        len = 16'(frame_w.size());
        chk = len[7:0] ^ len[15:8];
        send(8'hA5);
        check("sync_holds_cpu", 32'(o_cpu_rst), 32'd1);
        check("sync_clears_done", 32'(o_done), 32'd0);
        send(len[7:0]);
        send(len[15:8]);
        for (int i = 0; i < frame_w.size(); i++) begin
            exp_q.push_back({ADDR_W'(i), frame_w[i][8:0]});
            chk = chk ^ frame_w[i][7:0] ^ frame_w[i][15:8];
            send(frame_w[i][7:0]);
            send(frame_w[i][15:8]);
        end
        send(bad_chk ? ~chk : chk);
        idle(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        i_byte  = 8'h00;
        i_valid = 1'b0;
        idle(2);
        // reset values
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_we", 32'(o_rom_we), 32'd0);
        check("rst_addr", 32'(o_rom_addr), 32'd0);
        check("rst_data", 32'(o_rom_data), 32'd0);
        check("rst_cpu_rst", 32'(o_cpu_rst), 32'd1);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        rst_n = 1'b1;
        idle(1);
        check("ready_after_rst", 32'(o_ready), 32'd1);

        // good frame, literal bytes
        exp_q.push_back({ADDR_W'(0), 9'h001});
        exp_q.push_back({ADDR_W'(1), 9'h1FF});
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h01); send(8'h00); send(8'hFF); send(8'h01);
        check("good_cpu_held_pre_chk", 32'(o_cpu_rst), 32'd1);
        check("good_done_pre_chk", 32'(o_done), 32'd0);
        send(8'hFD);
        check("good_done", 32'(o_done), 32'd1);
        check("good_cpu_rst", 32'(o_cpu_rst), 32'd0);
        check("good_err", 32'(o_err), 32'd0);
        check("good_ready", 32'(o_ready), 32'd1);
        idle(2);
        check("good_queue", 32'(exp_q.size()), 32'd0);

        // bad checksum: words still land, CPU stays held
        exp_q.push_back({ADDR_W'(0), 9'h001});
        exp_q.push_back({ADDR_W'(1), 9'h1FF});
        send(8'hA5);
        check("reload_cpu_rst", 32'(o_cpu_rst), 32'd1);
        check("reload_done_clr", 32'(o_done), 32'd0);
        send(8'h02); send(8'h00);
        send(8'h01); send(8'h00); send(8'hFF); send(8'h01);
        send(8'h00);
        check("badchk_err", 32'(o_err), 32'd1);
        check("badchk_done", 32'(o_done), 32'd0);
        check("badchk_cpu_rst", 32'(o_cpu_rst), 32'd1);
        idle(2);
        check("badchk_queue", 32'(exp_q.size()), 32'd0);

        // empty frame
        send(8'hA5);
        check("err_cleared_by_sync", 32'(o_err), 32'd0);
        send(8'h00); send(8'h00); send(8'h00);
        check("empty_done", 32'(o_done), 32'd1);
        check("empty_cpu_rst", 32'(o_cpu_rst), 32'd0);
        idle(2);

        // garbage ahead of a good frame is discarded
        send(8'h12); send(8'h34);
        check("garbage_done_kept", 32'(o_done), 32'd1);
        check("garbage_cpu_rst", 32'(o_cpu_rst), 32'd0);
        frame_w = {};
        frame_w.push_back(16'h0001);
        frame_w.push_back(16'h01FF);
        send_frame(1'b0);
        check("garbage_frame_done", 32'(o_done), 32'd1);
        check("garbage_frame_cpu", 32'(o_cpu_rst), 32'd0);

        // oversize length (0x0801) aborts with no writes
        send(8'hA5); send(8'h01); send(8'h08);
        check("oversize_err", 32'(o_err), 32'd1);
        send(8'h01); send(8'h00);
        idle(2);
        check("oversize_err_kept", 32'(o_err), 32'd1);
        check("oversize_cpu_rst", 32'(o_cpu_rst), 32'd1);
        check("oversize_queue", 32'(exp_q.size()), 32'd0);

        // inter-byte timeout, then reload (SYNC value inside the frame is plain data)
        send(8'hA5); send(8'h03);
        idle(10);
        check("timeout_not_yet", 32'(o_err), 32'd0);
        idle(10);
        check("timeout_err", 32'(o_err), 32'd1);
        check("timeout_cpu_rst", 32'(o_cpu_rst), 32'd1);
        frame_w = {};
        frame_w.push_back(16'h00A5);
        frame_w.push_back(16'hFE55);
        frame_w.push_back(16'h0300);
        send_frame(1'b0);
        check("reload_done", 32'(o_done), 32'd1);
        check("reload_err", 32'(o_err), 32'd0);
        check("reload_cpu", 32'(o_cpu_rst), 32'd0);

        // reset after W_LO: the pending word is never written
        send(8'hA5); send(8'h02); send(8'h00); send(8'h01);
        i_byte  = 8'hFF;
        i_valid = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        check("midrst_we", 32'(o_rom_we), 32'd0);
        check("midrst_cpu_rst", 32'(o_cpu_rst), 32'd1);
        check("midrst_done", 32'(o_done), 32'd0);
        check("midrst_err", 32'(o_err), 32'd0);
        check("midrst_ready", 32'(o_ready), 32'd0);
        rst_n = 1'b1;
        idle(3);
        check("midrst_cpu_held", 32'(o_cpu_rst), 32'd1);
        check("midrst_queue", 32'(exp_q.size()), 32'd0);

        // full-ROM frame: LEN = 2^ADDR_W fills every address exactly once
        frame_w = {};
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            frame_w.push_back(16'(i * 37 + 5));
        end
        send_frame(1'b0);
        check("full_done", 32'(o_done), 32'd1);
        check("full_err", 32'(o_err), 32'd0);
        check("full_cpu", 32'(o_cpu_rst), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
